// File: rtl/seq_signed_multiplier.sv
// Purpose : signed WIDTH x WIDTH multiplier, one shift-add step per clock, sign-magnitude core.
// Latency : done pulses WIDTH+1 cycles after an accepted start (fewer with SEQ_MULT_EARLY_EXIT_EN).
// Backpr. : ready=0 while busy; start and operands are ignored (not queued) until ready returns.
// Optional: SEQ_MULT_EARLY_EXIT_EN stops iterating once the remaining multiplier magnitude is zero.
module seq_signed_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sign
);

    // Iteration counter must be able to reach WIDTH itself.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] shf_a;     // |A| pre-shifted by the current iteration index
    logic [WIDTH-1:0]   mag_b;     // remaining (right-shifted) |B|
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [CW-1:0]      iter;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               last_iter;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned WIDTH bits.
    always_comb begin
        abs_a = multiplicand[WIDTH-1] ? ({WIDTH{1'b0}} - multiplicand) : multiplicand;
        abs_b = multiplier[WIDTH-1]   ? ({WIDTH{1'b0}} - multiplier)   : multiplier;
    end

    // Decide whether the iteration being performed this cycle is the final one.
    always_comb begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last_iter = (iter == CW'(WIDTH - 1)) || (mag_b[WIDTH-1:1] == '0);
`else
        last_iter = (iter == CW'(WIDTH - 1));
`endif
    end

    // Control FSM and datapath; all outputs registered.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            product <= '0;
            sign    <= 1'b0;
            shf_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            iter    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shf_a <= {{WIDTH{1'b0}}, abs_a};
                        mag_b <= abs_b;
                        neg   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                        acc   <= '0;
                        iter  <= '0;
                        ready <= 1'b0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (mag_b[0]) begin
                        acc <= acc + shf_a;
                    end
                    shf_a <= shf_a << 1;
                    mag_b <= mag_b >> 1;
                    iter  <= iter + CW'(1);
                    if (last_iter) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    product <= neg ? ('0 - acc) : acc;
                    sign    <= neg & (|acc);
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Bench for seq_signed_multiplier: directed vectors on WIDTH=8 and WIDTH=16 instances,
// an arithmetic/latency model checked every cycle on the 8-bit instance,
// plus literal product/latency expectations per vector.
module tb_seq_signed_multiplier;

    logic clk;
    logic rst;

    logic              start8;
    logic signed [7:0] a8, b8;
    logic              ready8, done8, sign8;
    logic [15:0]       product8;

    logic               start16;
    logic signed [15:0] a16, b16;
    logic               ready16, done16, sign16;
    logic [31:0]        product16;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    seq_signed_multiplier #(.WIDTH(8)) dut8 (
        .sys_clk(clk), .rst(rst), .start(start8),
        .multiplicand(a8), .multiplier(b8),
        .ready(ready8), .done(done8), .product(product8), .sign(sign8)
    );

    seq_signed_multiplier #(.WIDTH(16)) dut16 (
        .sys_clk(clk), .rst(rst), .start(start16),
        .multiplicand(a16), .multiplier(b16),
        .ready(ready16), .done(done16), .product(product16), .sign(sign16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the 8-bit instance ----------------
    // Cycles from accepted start to visible done, derived from |B| only.
    function automatic int model_lat(input logic signed [7:0] b);
        int mag;
        int iters;
        mag = (b < 0) ? -int'(b) : int'(b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        iters = 1;
        for (int k = 0; k < 8; k++) begin
            if (mag[k]) iters = k + 1;
        end
`else
        iters = 8;
`endif
        return iters + 1;
    endfunction

    int          m_p;
    logic        m_ready, m_done, m_sign, m_pend_neg;
    logic [15:0] m_prod, m_pend;
    int          m_cnt;

    always_comb m_p = int'(a8) * int'(b8);

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_prod  <= '0;
            m_sign  <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done  <= 1'b1;
                    m_ready <= 1'b1;
                    m_prod  <= m_pend;
                    m_sign  <= m_pend_neg;
                end
            end else if (m_ready && start8) begin
                m_ready    <= 1'b0;
                m_cnt      <= model_lat(b8);
                m_pend     <= m_p[15:0];
                m_pend_neg <= (m_p < 0);
            end
        end
    end

    // Cycle-by-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model ready",   {31'd0, ready8}, {31'd0, m_ready});
            chk("model done",    {31'd0, done8},  {31'd0, m_done});
            chk("model product", {16'd0, product8}, {16'd0, m_prod});
            chk("model sign",    {31'd0, sign8},  {31'd0, m_sign});
        end
    end

    // ---------------- directed stimulus ----------------
    // Issue one 8-bit operation from a cycle where ready=1, then check literal results.
    task automatic do_op(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic [15:0] ep, input logic es,
                         input int lat_fixed, input int lat_early, input string nm);
        int n;
        int lat;
        logic got;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        lat = lat_early;
`else
        lat = lat_fixed;
`endif
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done8) got = 1'b1;
        end
        chk({nm, " latency"}, n, lat);
        chk({nm, " product"}, {16'd0, product8}, {16'd0, ep});
        chk({nm, " sign"},    {31'd0, sign8},    {31'd0, es});
    endtask

    initial begin
        int n;
        int pulses;
        logic got;

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready",   {31'd0, ready8}, 32'd1);
        chk("reset done",    {31'd0, done8},  32'd0);
        chk("reset product", {16'd0, product8}, 32'd0);
        chk("reset sign",    {31'd0, sign8},  32'd0);
        chk("reset ready16", {31'd0, ready16}, 32'd1);
        chk("reset product16", product16, 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'sd127, 8'sd127, 16'h3F01, 1'b0, 9, 8, "127x127");
        do_op(-8'sd7,  8'sd6,   16'hFFD6, 1'b1, 9, 4, "-7x6");
        do_op(8'sd0,   8'sd5,   16'h0000, 1'b0, 9, 4, "0x5");
        // back-to-back: second start raised in the done cycle of the first
        do_op(-8'sd128, -8'sd128, 16'h4000, 1'b0, 9, 9, "-128x-128");
        do_op(-8'sd128, 8'sd127,  16'hC080, 1'b1, 9, 8, "-128x127");
        do_op(8'sd8,   8'sd6,   16'd48,   1'b0, 9, 4, "8x6");

        // Start and operand changes while busy must be ignored.
        @(negedge clk);
        a8 = 8'sd5; b8 = -8'sd99; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(posedge clk);
        #1 begin a8 = 8'sd100; b8 = 8'sd100; start8 = 1'b1; end
        repeat (2) @(posedge clk);
        #1 start8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        chk("busy-start done pulses", pulses, 32'd1);
        chk("busy-start product", {16'd0, product8}, 32'h0000FE11);
        chk("busy-start sign", {31'd0, sign8}, 32'd1);

        // Reset four cycles into the calculation aborts it.
        a8 = 8'sd3; b8 = -8'sd127; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort ready", {31'd0, ready8}, 32'd1);
        chk("abort product", {16'd0, product8}, 32'd0);
        chk("abort sign", {31'd0, sign8}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        chk("abort done pulses", pulses, 32'd0);
        do_op(-8'sd7, 8'sd6, 16'hFFD6, 1'b1, 9, 4, "post-abort -7x6");

        // 16-bit instance, extreme operands.
        a16 = -16'sd32768; b16 = 16'sd32767; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done16) got = 1'b1;
        end
`ifdef SEQ_MULT_EARLY_EXIT_EN
        chk("w16 latency", n, 32'd16);
`else
        chk("w16 latency", n, 32'd17);
`endif
        chk("w16 product", product16, 32'hC0008000);
        chk("w16 sign", {31'd0, sign16}, 32'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
